sram_req_sequencer: RTL and testbench

//  Host-side front end for sram_top. Accepts parallel read/write requests on a

---
 rtl/sram_req_sequencer_if.sv | 33 +++
 rtl/sram_req_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_sram_req_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_req_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_req_sequencer_if
//  Purpose  : Host-side request/response bundle for sram_req_sequencer.
//             The master modport belongs to the host and the slave modport
//             to the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_req_sequencer_if #(
   parameter int AW   = 4,
   parameter int COLS = 8
);
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [AW-1:0]   req_addr;
   logic [COLS-1:0] req_wdata;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [COLS-1:0] rsp_rdata;
   logic            rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/sram_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sram_req_sequencer
//  Purpose  : Host-side front end for sram_top. Writes become an LSB-first
//             serial shift burst followed by a single w_en pulse; reads become
//             an r_en pulse, a wait for data_valid and a held response.
//             Optional read timeout: define SRAM_SEQ_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module sram_req_sequencer #(
   parameter int ROWS       = 16,
   parameter int COLS       = 8,
   parameter int RD_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      arst_n,
   sram_req_sequencer_if.slave       bus,
   output logic                      busy,
   output logic                      sram_serial_in,
   output logic                      sram_shift,
   output logic                      sram_w_en,
   output logic                      sram_r_en,
   output logic [$clog2(ROWS)-1:0]   sram_addr,
   input  logic                      sram_data_valid,
   input  logic [COLS-1:0]           sram_data_out
);

   localparam int c_AW = $clog2(ROWS);
   localparam int c_CW = $clog2(COLS + 1);
   localparam logic [c_CW-1:0] c_LAST_BIT = c_CW'(COLS - 1);
   localparam logic [c_AW:0]   c_ROWS     = (c_AW + 1)'(ROWS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SHIFT = 3'd1,
      S_WRITE = 3'd2,
      S_READ  = 3'd3,
      S_WAIT  = 3'd4,
      S_RESP  = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_live;       // low for the cycle(s) following a reset edge
   logic [c_AW-1:0]   r_addr;
   logic [COLS-1:0]   r_sreg;       // write data, consumed LSB first
   logic [c_CW-1:0]   r_bit_cnt;
   logic [COLS-1:0]   r_rdata;
   logic              r_err;
   logic              w_accept;
   logic              w_addr_oor;
   logic              w_wait_expired;

   // A request is taken only in IDLE and never in the cycle right after reset.
   assign w_accept   = (r_state == S_IDLE) && r_live && bus.req_valid;
   // Addresses past the last row can only occur for non-power-of-2 ROWS.
   assign w_addr_oor = ({1'b0, bus.req_addr} >= c_ROWS);

`ifdef SRAM_SEQ_TIMEOUT_EN
   localparam int c_TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(RD_TIMEOUT - 1);

   logic [c_TW-1:0] r_wait_cnt;

   // Count cycles spent in WAIT, starting from zero on entry.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
         r_wait_cnt <= '0;
      end
   end

   assign w_wait_expired = (r_state == S_WAIT) && (r_wait_cnt == c_TMO_LAST);
`else
   // Without the timeout build WAIT holds until data_valid arrives.
   assign w_wait_expired = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and state-driven outputs.
   always_comb begin
      w_state_nxt    = r_state;
      bus.req_ready  = 1'b0;
      bus.rsp_valid  = 1'b0;
      busy           = 1'b1;
      sram_shift     = 1'b0;
      sram_w_en      = 1'b0;
      sram_r_en      = 1'b0;
      sram_serial_in = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy          = 1'b0;
            bus.req_ready = r_live;
            if (w_accept) begin
               if (bus.req_write) begin
                  w_state_nxt = w_addr_oor ? S_IDLE : S_SHIFT;
               end else begin
                  w_state_nxt = w_addr_oor ? S_RESP : S_READ;
               end
            end
         end
         S_SHIFT: begin
            sram_shift     = 1'b1;
            sram_serial_in = r_sreg[0];
            if (r_bit_cnt == c_LAST_BIT) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            sram_w_en   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_READ: begin
            sram_r_en   = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (sram_data_valid || w_wait_expired) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Request latch, shift datapath and response capture.
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_live    <= 1'b0;
         r_addr    <= '0;
         r_sreg    <= '0;
         r_bit_cnt <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_addr    <= bus.req_addr;
                  r_sreg    <= bus.req_wdata;
                  r_bit_cnt <= '0;
                  if (!bus.req_write && w_addr_oor) begin
                     r_rdata <= '0;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_SHIFT: begin
               r_sreg    <= r_sreg >> 1;
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            S_WAIT: begin
               // Data arriving on the expiry cycle still wins over the timeout.
               if (sram_data_valid) begin
                  r_rdata <= sram_data_out;
                  r_err   <= 1'b0;
               end else if (w_wait_expired) begin
                  r_rdata <= '0;
                  r_err   <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;
   assign sram_addr     = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_sram_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_req_sequencer
//  Purpose  : Self-checking bench for sram_req_sequencer with a behavioural
//             SRAM attached to the serial side and a word-level memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_req_sequencer;

   localparam int ROWS       = 12;
   localparam int COLS       = 8;
   localparam int RD_TIMEOUT = 8;
   localparam int AW         = 4;

   logic          clk = 1'b0;
   logic          arst_n;
   logic          busy;
   logic          sram_serial_in;
   logic          sram_shift;
   logic          sram_w_en;
   logic          sram_r_en;
   logic [AW-1:0] sram_addr;
   logic          sram_data_valid;
   logic [7:0]    sram_data_out;

   int n_checks = 0;
   int n_fail   = 0;

   sram_req_sequencer_if #(.AW(AW), .COLS(COLS)) bus ();

   sram_req_sequencer #(
      .ROWS(ROWS), .COLS(COLS), .RD_TIMEOUT(RD_TIMEOUT)
   ) dut (
      .clk(clk), .arst_n(arst_n), .bus(bus), .busy(busy),
      .sram_serial_in(sram_serial_in), .sram_shift(sram_shift),
      .sram_w_en(sram_w_en), .sram_r_en(sram_r_en), .sram_addr(sram_addr),
      .sram_data_valid(sram_data_valid), .sram_data_out(sram_data_out)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM on the serial side: shift register, word array, and a
   // data_valid that fires env_lat cycles after r_en (env_lat=0: never).
   logic [7:0] env_mem [0:15] = '{default: 8'h00};
   logic [7:0] env_sh  = 8'h00;
   logic [3:0] env_ra  = 4'h0;
   int         env_cd  = 0;
   int         env_lat = 1;
   bit         tb_dv   = 1'b0;

   always @(posedge clk) begin
      if (sram_shift) env_sh <= {sram_serial_in, env_sh[7:1]};
      if (sram_w_en)  env_mem[sram_addr] <= env_sh;
      if (sram_r_en && env_lat > 0) begin
         env_cd <= env_lat;
         env_ra <= sram_addr;
      end else if (env_cd > 0) begin
         env_cd <= env_cd - 1;
      end
   end

   assign sram_data_valid = (env_cd == 1) | tb_dv;
   assign sram_data_out   = tb_dv ? 8'hEE : ((env_cd == 1) ? env_mem[env_ra] : 8'hC3);

   // Word-level reference: what each in-range address should hold.
   logic [7:0] ref_mem [0:15] = '{default: 8'h00};

   typedef struct {
      bit         wr;
      logic [3:0] addr;
      logic [7:0] data;
      int         lat;
      int         hold;
      logic [7:0] exp_d;
      bit         exp_e;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("strobe_exclusive", 32'(($countones({sram_shift, sram_w_en, sram_r_en}) <= 1)), 1);
   endtask

   task automatic chk_all_zero(input string nm);
      chk(nm, {bus.req_ready, busy, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
               sram_shift, sram_w_en, sram_r_en, sram_serial_in, sram_addr}, 0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("req_ready_wait", bus.req_ready, 1);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d, input bit pulse_dv);
      bit oor = (a >= ROWS);
      wait_ready();
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_wdata = d;
      tick();
      bus.req_valid = 1'b0; bus.req_addr = ~a; bus.req_wdata = ~d;
      if (oor) begin
         chk("oor_wr_ready", bus.req_ready, 1);
         chk("oor_wr_shift", sram_shift, 0);
         chk("oor_wr_wen", sram_w_en, 0);
      end else begin
         for (int k = 0; k < COLS; k++) begin
            if (k > 0) tick();
            tb_dv = pulse_dv && (k == 3);
            chk("wr_shift", sram_shift, 1);
            chk("wr_serial_bit", sram_serial_in, d[k]);
            chk("wr_busy_ready", {busy, bus.req_ready}, 2'b10);
            chk("wr_no_rsp", bus.rsp_valid, 0);
         end
         tb_dv = 1'b0;
         tick();
         chk("wr_wen", {sram_w_en, sram_shift}, 2'b10);
         chk("wr_addr", sram_addr, a);
         tick();
         chk("wr_ready_back", bus.req_ready, 1);
         chk("wr_no_rsp_after", bus.rsp_valid, 0);
         ref_mem[a] = d;
      end
   endtask

   task automatic do_read(input logic [3:0] a, input int lat, input int hold,
                          input logic [7:0] exp_d, input bit exp_e, input bit expect_tmo);
      bit oor = (a >= ROWS);
      int exp_idx;
      if (oor)             exp_idx = 1;
      else if (expect_tmo) exp_idx = 2 + RD_TIMEOUT;
      else                 exp_idx = 2 + lat;
      env_lat = lat;
      wait_ready();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_wdata = 8'h99;
      for (int i = 1; i <= exp_idx; i++) begin
         tick();
         if (i == 1) begin
            bus.req_valid = 1'b0; bus.req_addr = ~a;
            chk("rd_ren", sram_r_en, !oor);
            chk("rd_busy", busy, 1);
            if (!oor) chk("rd_addr", sram_addr, a);
         end else begin
            chk("rd_ren_once", sram_r_en, 0);
         end
         chk("rsp_valid_timing", bus.rsp_valid, (i == exp_idx));
      end
      for (int h = 0; h <= hold; h++) begin
         if (h > 0) tick();
         chk("rsp_valid_hold", bus.rsp_valid, 1);
         chk("rsp_rdata", bus.rsp_rdata, exp_d);
         chk("rsp_err", bus.rsp_err, exp_e);
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("rsp_done_valid", bus.rsp_valid, 0);
      chk("rsp_done_ready", bus.req_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.rsp_ready = 1'b0;

      tbl[0]  = '{1'b1, 4'd5,  8'hA5, 0, 0, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 4'd5,  8'h00, 2, 4, 8'hA5, 1'b0};
      tbl[2]  = '{1'b1, 4'd3,  8'h00, 0, 0, 8'h00, 1'b0};
      tbl[3]  = '{1'b1, 4'd11, 8'hFF, 0, 0, 8'h00, 1'b0};
      tbl[4]  = '{1'b0, 4'd3,  8'h00, 1, 0, 8'h00, 1'b0};
      tbl[5]  = '{1'b0, 4'd11, 8'h00, 3, 1, 8'hFF, 1'b0};
      tbl[6]  = '{1'b1, 4'd12, 8'h77, 0, 0, 8'h00, 1'b0};
      tbl[7]  = '{1'b0, 4'd12, 8'h00, 1, 0, 8'h00, 1'b1};
      tbl[8]  = '{1'b0, 4'd15, 8'h00, 1, 2, 8'h00, 1'b1};
      tbl[9]  = '{1'b0, 4'd5,  8'h00, 4, 0, 8'hA5, 1'b0};
      tbl[10] = '{1'b1, 4'd0,  8'h3C, 0, 0, 8'h00, 1'b0};
      tbl[11] = '{1'b0, 4'd0,  8'h00, 1, 0, 8'h3C, 1'b0};

      // Reset state and first cycle after release.
      arst_n = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset_outputs");
      arst_n = 1'b1;
      tick();
      chk("ready_after_reset", bus.req_ready, 1);

      // Reset held three cycles in the middle of a shift burst.
      wait_ready();
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 4'd5; bus.req_wdata = 8'hFF;
      tick();
      bus.req_valid = 1'b0;
      tick(); tick();
      chk("mid_shift", sram_shift, 1);
      arst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all_zero("mid_reset_outputs");
      end
      arst_n = 1'b1;
      tick();
      chk("ready_after_mid_reset", bus.req_ready, 1);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("no_wen_after_abort", {sram_w_en, sram_shift, bus.rsp_valid}, 0);
      end

      // Directed vector table.
      foreach (tbl[i]) begin
         if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data, 1'b0);
         else do_read(tbl[i].addr, tbl[i].lat, tbl[i].hold, tbl[i].exp_d, tbl[i].exp_e, 1'b0);
      end

      // data_valid while IDLE is ignored.
      wait_ready();
      tb_dv = 1'b1;
      tick();
      tb_dv = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("idle_dv_ignored", {bus.rsp_valid, busy, bus.req_ready}, 3'b001);
         tick();
      end
      // data_valid during SHIFT is ignored; the written word must still land.
      do_write(4'd7, 8'h5B, 1'b1);
      do_read(4'd7, 1, 0, ref_mem[7], 1'b0, 1'b0);

      // Back-to-back: fill every address, then read all back.
      for (int a = 0; a < 16; a++) do_write(4'(a), 8'(a) ^ 8'h3C, 1'b0);
      for (int a = 0; a < 16; a++) begin
         if (a < ROWS) do_read(4'(a), 1, 0, 8'(a) ^ 8'h3C, 1'b0, 1'b0);
         else          do_read(4'(a), 1, 0, 8'h00, 1'b1, 1'b0);
      end

      // Randomized traffic against the word-level reference.
      for (int n = 0; n < 40; n++) begin
         logic [3:0] a;
         logic [7:0] d;
         a = 4'($urandom_range(0, 15));
         d = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            do_write(a, d, 1'b0);
         end else if (a >= ROWS) begin
            do_read(a, $urandom_range(1, 4), $urandom_range(0, 3), 8'h00, 1'b1, 1'b0);
         end else begin
            do_read(a, $urandom_range(1, 4), $urandom_range(0, 3), ref_mem[a], 1'b0, 1'b0);
         end
      end

`ifdef SRAM_SEQ_TIMEOUT_EN
      // No data at all, then data arriving only after the timeout fired.
      do_read(4'd2, 0, 1, 8'h00, 1'b1, 1'b1);
      do_read(4'd2, RD_TIMEOUT + 2, 3, 8'h00, 1'b1, 1'b1);
      do_read(4'd2, 1, 0, ref_mem[2], 1'b0, 1'b0);
`else
      // Without the timeout, a long wait still completes with good data.
      do_read(4'd2, 20, 0, ref_mem[2], 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
